// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: dynamic phase-shift sequencer for the fractional PLL.
// Walks one PLL output counter a single step at a time through the
// phase_en/updn/cntsel/phase_done handshake and keeps a signed running
// offset per channel. Optional phase_done watchdog: define PLL_PHASE_TIMEOUT_EN.
module pll_phase_ctrl #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 5,
  parameter int STEP_W = 9,
  parameter int EN_CYC = 2,
  parameter int TO_CYC = 1023,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_pll_locked,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [CH_W-1:0]          i_req_ch,
  input  logic [STEP_W-1:0]        i_req_steps,
  output logic                     o_phase_en,
  output logic                     o_updn,
  output logic [CNT_W-1:0]         o_cntsel,
  input  logic                     i_phase_done,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
  output logic [NUM_CH*STEP_W-1:0] o_ofs_flat
);

  localparam int EC_W = (EN_CYC > 1) ? $clog2(EN_CYC) : 1;
  localparam int WD_W = $clog2(TO_CYC + 1);
`ifdef PLL_PHASE_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_WAIT_LO, S_WAIT_HI, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CH_W-1:0]   r_ch;
  logic              r_updn;
  logic [STEP_W-1:0] r_rem;
  logic [EC_W-1:0]   r_en_cnt;
  logic [WD_W-1:0]   r_wd;
  logic              r_done_pulse;
  logic              r_err_pulse;

  logic              w_ready;
  logic              w_accept;
  logic              w_ch_bad;
  logic              w_zero;
  logic              w_start;
  logic              w_active;
  logic              w_waiting;
  logic              w_step_ok;
  logic              w_wd_hit;
  logic              w_abort;
  logic              w_en_last;
  logic [STEP_W-1:0] w_abs;

  // Request decode and step/abort conditions shared by FSM and datapath
  always_comb begin
    w_ready   = (r_state == S_IDLE) & i_pll_locked & i_rst_n;
    w_accept  = i_req_valid & w_ready;
    w_ch_bad  = (32'(i_req_ch) >= NUM_CH);
    w_zero    = (i_req_steps == '0);
    w_start   = w_accept & ~w_ch_bad & ~w_zero;
    // most-negative request maps to 2^(STEP_W-1), still representable unsigned
    w_abs     = i_req_steps[STEP_W-1] ? (~i_req_steps + STEP_W'(1)) : i_req_steps;
    w_active  = (r_state != S_IDLE) && (r_state != S_DONE);
    w_waiting = (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);
    // a completing step is always counted, even when lock drops in the same cycle
    w_step_ok = (r_state == S_WAIT_HI) & i_phase_done;
    w_wd_hit  = WD_EN & w_waiting & (r_wd == WD_W'(TO_CYC - 1)) & ~w_step_ok;
    w_abort   = w_active & ~i_pll_locked;
    w_en_last = (r_en_cnt == EC_W'(EN_CYC - 1));
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // FSM next-state logic; lock loss and watchdog override every transition
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_state_next = S_SETUP;
      S_SETUP:   w_state_next = S_PULSE;
      S_PULSE:   if (w_en_last) w_state_next = S_WAIT_LO;
      S_WAIT_LO: if (!i_phase_done) w_state_next = S_WAIT_HI;
      S_WAIT_HI: if (i_phase_done)
                   w_state_next = (r_rem == STEP_W'(1)) ? S_DONE : S_SETUP;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
    if (w_abort || w_wd_hit) w_state_next = S_IDLE;
  end

  // FSM outputs; phase_en drops combinationally the cycle lock is lost
  always_comb begin
    o_req_ready = w_ready;
    o_phase_en  = (r_state == S_PULSE) & i_pll_locked;
    o_busy      = (r_state != S_IDLE);
    o_done      = (r_state == S_DONE) | r_done_pulse;
    o_err       = r_err_pulse;
    o_updn      = r_updn;
    o_cntsel    = CNT_W'(r_ch);
  end

  // Request latch, remaining-step count, pulse-width and watchdog counters
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ch         <= '0;
      r_updn       <= 1'b0;
      r_rem        <= '0;
      r_en_cnt     <= '0;
      r_wd         <= '0;
      r_done_pulse <= 1'b0;
      r_err_pulse  <= 1'b0;
    end else begin
      r_done_pulse <= w_accept & ~w_ch_bad & w_zero;
      r_err_pulse  <= (w_accept & w_ch_bad) | w_abort | w_wd_hit;
      if (w_start) begin
        r_ch   <= i_req_ch;
        r_updn <= ~i_req_steps[STEP_W-1];
        r_rem  <= w_abs;
      end else if (w_step_ok) begin
        r_rem  <= r_rem - STEP_W'(1);
      end
      r_en_cnt <= (r_state == S_PULSE) ? r_en_cnt + EC_W'(1) : '0;
      r_wd     <= w_waiting ? r_wd + WD_W'(1) : '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ofs
      logic [STEP_W-1:0] r_ofs;
      // Per-channel offset: wraps modulo 2^STEP_W on each completed step
      always_ff @(posedge i_clk) begin
        if (!i_rst_n)
          r_ofs <= '0;
        else if (w_step_ok && (32'(r_ch) == gi))
          r_ofs <= r_updn ? r_ofs + STEP_W'(1) : r_ofs - STEP_W'(1);
      end
      assign o_ofs_flat[gi*STEP_W +: STEP_W] = r_ofs;
    end
  endgenerate

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Self-checking bench for pll_phase_ctrl: table-driven corner vectors,
// hand-written reset/lock/busy/watchdog sequences and randomized requests
// checked against a per-channel offset model.
module tb_pll_phase_ctrl;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 5;
  localparam int STEP_W = 9;
  localparam int EN_CYC = 2;
  localparam int TO_CYC = 16;
  localparam int CH_W   = 2;
  localparam int FW     = NUM_CH * STEP_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pll_locked = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [CH_W-1:0]   req_ch = '0;
  logic [STEP_W-1:0] req_steps = '0;
  logic              phase_en;
  logic              updn;
  logic [CNT_W-1:0]  cntsel;
  logic              phase_done = 1'b1;
  logic              busy;
  logic              done;
  logic              err;
  logic [FW-1:0]     ofs_flat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pll_phase_ctrl #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .STEP_W(STEP_W), .EN_CYC(EN_CYC), .TO_CYC(TO_CYC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pll_locked(pll_locked),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_ch(req_ch), .i_req_steps(req_steps),
    .o_phase_en(phase_en), .o_updn(updn), .o_cntsel(cntsel),
    .i_phase_done(phase_done), .o_busy(busy), .o_done(done), .o_err(err),
    .o_ofs_flat(ofs_flat)
  );

  // PLL model: on a phase_en rising edge phase_done goes low for pll_lo cycles
  int   pll_lo = 4;
  bit   pll_stall = 1'b0;
  int   lo_cnt = 0;
  logic pe_prev = 1'b0;
  always @(posedge clk) begin
    if (phase_en && !pe_prev && !pll_stall) lo_cnt = pll_lo;
    else if (lo_cnt > 0) lo_cnt = lo_cnt - 1;
    pe_prev = phase_en;
    phase_done <= (lo_cnt == 0);
  end

  initial begin
    #(10 * 60000);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: accumulated offset per channel, modulo 2^STEP_W
  int mofs[NUM_CH];
  function automatic logic [FW-1:0] model_flat();
    logic [FW-1:0] f = '0;
    for (int c = 0; c < NUM_CH; c++) f[c*STEP_W +: STEP_W] = STEP_W'(mofs[c]);
    return f;
  endfunction
  function automatic void model_apply(input int ch, input int delta);
    if (ch < NUM_CH) mofs[ch] = (mofs[ch] + delta) & ((1 << STEP_W) - 1);
  endfunction

  int res_done, res_err, res_pulse, res_pecyc, res_badsel, res_baddir;
  int res_lat, res_done_at, res_err_at, res_tmo;

  // modes: 0 plain, 1 hammer req_valid while busy, 2 drop lock in WAIT_LO after pulse k,
  //        3 drop lock in the first phase_en cycle
  task automatic run_req(input int ch, input int steps, input bit exp_dir,
                         input int mode, input int k, input int limit);
    int cyc;
    int tail;
    bit pe;
    bit pe_last;
    res_done = 0; res_err = 0; res_pulse = 0; res_pecyc = 0;
    res_badsel = 0; res_baddir = 0; res_lat = -1; res_done_at = -1;
    res_err_at = -1; res_tmo = 0;
    cyc = 0;
    while (!req_ready && cyc < 200) begin @(negedge clk); cyc++; end
    if (!req_ready) res_tmo = 1;
    req_ch = CH_W'(ch);
    req_steps = STEP_W'(steps);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    pe_last = 1'b0;
    tail = 0;
    cyc = 1;
    while (cyc <= limit && tail < 3) begin
      pe = phase_en;
      if (pe) begin
        res_pecyc++;
        if (!pe_last) begin res_pulse++; if (res_lat < 0) res_lat = cyc; end
        if (32'(cntsel) != ch) res_badsel++;
        if (updn != exp_dir) res_baddir++;
      end
      if (done) begin res_done++; if (res_done_at < 0) res_done_at = cyc; end
      if (err) begin res_err++; if (res_err_at < 0) res_err_at = cyc; end
      if (mode == 2 && !pe && pe_last && res_pulse == k) pll_locked = 1'b0;
      if (mode == 3 && pe && !pe_last && res_pulse == 1) begin
        pll_locked = 1'b0;
        #1;
        chk("lock_drop_phase_en_same_cycle", phase_en, 0);
      end
      if (mode == 1) begin
        req_valid = busy && !done;
        req_ch = CH_W'((ch + 1) % NUM_CH);
        req_steps = STEP_W'(4);
      end
      pe_last = pe;
      if (!busy && (res_done + res_err) > 0) tail++;
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    if (tail < 3) res_tmo = 1;
    $display("txn ch=%0d steps=%0d mode=%0d pulses=%0d done=%0d err=%0d ofs_flat=%h",
             ch, steps, mode, res_pulse, res_done, res_err, ofs_flat);
  endtask

  task automatic check_normal(input int ch, input int steps);
    int n;
    bit ok;
    n  = (steps < 0) ? -steps : steps;
    ok = (ch < NUM_CH);
    chk("rnd_complete", res_tmo, 0);
    chk("rnd_pulses", res_pulse, ok ? n : 0);
    chk("rnd_pe_cycles", res_pecyc, ok ? n * EN_CYC : 0);
    chk("rnd_done", res_done, ok ? 1 : 0);
    chk("rnd_err", res_err, ok ? 0 : 1);
    chk("rnd_cntsel_bad", res_badsel, 0);
    chk("rnd_updn_bad", res_baddir, 0);
    if (ok) model_apply(ch, steps);
    chk("rnd_ofs_flat", ofs_flat, model_flat());
    if (ok && n > 0) chk("rnd_first_pe_latency", res_lat, 2);
    if (ok && n == 0) chk("rnd_zero_done_at", res_done_at, 1);
    if (!ok) chk("rnd_bad_ch_err_at", res_err_at, 1);
  endtask

  typedef struct {
    int            ch;
    int            steps;
    int            pulses;
    bit            updn;
    bit            done;
    bit            err;
    logic [FW-1:0] flat;
  } vec_t;

  vec_t tbl[7];
  int   rdy_cnt;

  initial begin
    tbl[0] = '{1,    3,   3, 1'b1, 1'b1, 1'b0, 27'h0000600};
    tbl[1] = '{0, -255, 255, 1'b0, 1'b1, 1'b0, 27'h0000701};
    tbl[2] = '{0,   -2,   2, 1'b0, 1'b1, 1'b0, 27'h00006FF};
    tbl[3] = '{2,    0,   0, 1'b0, 1'b1, 1'b0, 27'h00006FF};
    tbl[4] = '{3,    5,   0, 1'b0, 1'b0, 1'b1, 27'h00006FF};
    tbl[5] = '{2,    1,   1, 1'b1, 1'b1, 1'b0, 27'h00406FF};
    tbl[6] = '{1, -256, 256, 1'b0, 1'b1, 1'b0, 27'h00606FF};
    for (int c = 0; c < NUM_CH; c++) mofs[c] = 0;

    // power-on reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("por_req_ready", req_ready, 0);
    chk("por_busy", busy, 0);
    chk("por_ofs_flat", ofs_flat, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("por_release_req_ready", req_ready, 1);

    // reset held 3 cycles in the middle of a PULSE
    req_ch = 2'd1; req_steps = 9'd3; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_in_pulse", phase_en, 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_phase_en", phase_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_updn", updn, 0);
    chk("rst_cntsel", cntsel, 0);
    chk("rst_ofs_flat", ofs_flat, 0);
    chk("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_req_ready", req_ready, 1);
    repeat (8) @(negedge clk);

    // table-driven vectors
    pll_lo = 4;
    for (int i = 0; i < 7; i++) begin
      run_req(tbl[i].ch, tbl[i].steps, tbl[i].updn, 0, 0, 5000);
      chk($sformatf("tbl%0d_complete", i), res_tmo, 0);
      chk($sformatf("tbl%0d_pulses", i), res_pulse, tbl[i].pulses);
      chk($sformatf("tbl%0d_pe_cycles", i), res_pecyc, tbl[i].pulses * EN_CYC);
      chk($sformatf("tbl%0d_done", i), res_done, tbl[i].done);
      chk($sformatf("tbl%0d_err", i), res_err, tbl[i].err);
      chk($sformatf("tbl%0d_ofs_flat", i), ofs_flat, tbl[i].flat);
      if (tbl[i].pulses > 0) begin
        chk($sformatf("tbl%0d_cntsel_bad", i), res_badsel, 0);
        chk($sformatf("tbl%0d_updn_bad", i), res_baddir, 0);
        chk($sformatf("tbl%0d_first_pe_latency", i), res_lat, 2);
      end else if (tbl[i].done) begin
        chk($sformatf("tbl%0d_done_at", i), res_done_at, 1);
      end else begin
        chk($sformatf("tbl%0d_err_at", i), res_err_at, 1);
      end
      if (tbl[i].ch < NUM_CH) model_apply(tbl[i].ch, tbl[i].steps);
    end

    // req_valid held while busy must be ignored
    run_req(2, 2, 1'b1, 1, 0, 500);
    check_normal(2, 2);

    // lock lost in WAIT_LO of step 3 of a +5 walk
    run_req(2, 5, 1'b1, 2, 3, 500);
    chk("lock_wl_pulses", res_pulse, 3);
    chk("lock_wl_err", res_err, 1);
    chk("lock_wl_done", res_done, 0);
    model_apply(2, 2);
    chk("lock_wl_ofs_flat", ofs_flat, model_flat());
    rdy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (req_ready) rdy_cnt++;
      @(negedge clk);
    end
    chk("lock_wl_ready_while_unlocked", rdy_cnt, 0);
    pll_locked = 1'b1;
    @(negedge clk);
    chk("lock_wl_ready_after_relock", req_ready, 1);
    repeat (6) @(negedge clk);

    // lock lost during the first PULSE cycle
    run_req(0, 1, 1'b1, 3, 0, 500);
    chk("lock_pe_err", res_err, 1);
    chk("lock_pe_err_at", res_err_at, 3);
    chk("lock_pe_done", res_done, 0);
    chk("lock_pe_ofs_flat", ofs_flat, model_flat());
    pll_locked = 1'b1;
    repeat (6) @(negedge clk);

    // phase_done never falls
    pll_stall = 1'b1;
`ifdef PLL_PHASE_TIMEOUT_EN
    run_req(1, 1, 1'b1, 0, 0, 400);
    chk("wd_err", res_err, 1);
    chk("wd_done", res_done, 0);
    chk("wd_err_at", res_err_at, 2 + EN_CYC + TO_CYC);
    chk("wd_ofs_flat", ofs_flat, model_flat());
`else
    run_req(1, 1, 1'b1, 0, 0, 200);
    chk("nowd_busy_held", busy, 1);
    chk("nowd_err", res_err, 0);
    chk("nowd_done", res_done, 0);
    pll_locked = 1'b0;
    @(negedge clk);
    chk("nowd_abort_err", err, 1);
    pll_locked = 1'b1;
    @(negedge clk);
    chk("nowd_abort_busy", busy, 0);
    chk("nowd_ofs_flat", ofs_flat, model_flat());
`endif
    pll_stall = 1'b0;
    repeat (4) @(negedge clk);

    // randomized requests against the offset model
    for (int i = 0; i < 24; i++) begin
      int ch;
      int steps;
      ch = int'($urandom_range(0, 3));
      steps = int'($urandom_range(0, 14)) - 7;
      pll_lo = int'($urandom_range(2, 6));
      run_req(ch, steps, steps > 0, 0, 0, 3000);
      check_normal(ch, steps);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
